squash_recovery_ctrl: RTL
=========================

Name: squash_recovery_ctrl

Overview:
Sequences branch-mispredict recovery for the rename datapath (ROB, map table, free list). On a squash request it freezes dispatch, then walks the ROB backwards from the tail, youngest first, undoing up to N_WAY entries per cycle. For each undone entry it restores the map-table mapping (dest -> tag_old) and returns the allocated tag to the free list. It then releases dispatch.

Parameters:
N_WAY, 2, superscalar width; maximum entries undone per cycle
N_ROB, 32, ROB entries; power of two
CDB_BITS, 6, physical tag width
ARCH_BITS, 5, architectural register index width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
squash_req  in  1  mispredict pulse
squash_rob_idx  in  $clog2(N_ROB)  ROB index of the mispredicted branch; all younger entries are undone
rob_head  in  $clog2(N_ROB)  ROB head (oldest entry), used for age compare
rob_tail  in  $clog2(N_ROB)  ROB tail (next free slot)
rd_idx  out  N_WAY x $clog2(N_ROB)  ROB read addresses, lane 0 youngest
rd_tag  in  N_WAY x CDB_BITS  tag at rd_idx, same cycle
rd_told  in  N_WAY x CDB_BITS  tag_old at rd_idx, same cycle
rd_dest  in  N_WAY x ARCH_BITS  arch dest at rd_idx, same cycle
restore_valid  out  N_WAY  map-table restore strobe per lane
restore_dest  out  N_WAY x ARCH_BITS  arch reg to restore
restore_tag  out  N_WAY x CDB_BITS  value to write (= rd_told)
free_valid  out  N_WAY  free-list return strobe per lane
free_tag  out  N_WAY x CDB_BITS  tag returned (= rd_tag)
rob_tail_dec  out  $clog2(N_WAY)+1  number of entries popped from the ROB tail this cycle
dispatch_stall  out  1  blocks dispatch
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when recovery completes

Behaviour:
- States are IDLE, WALK and DONE. reset==0 at a clock edge forces IDLE, zeroes ptr/target/remaining, and drives all outputs to 0 from the next cycle. This holds even when reset arrives mid-WALK; the partial undo is not completed.
- Index arithmetic is mod N_ROB. Age(x) = (x - rob_head) mod N_ROB.
- IDLE + squash_req:
  - latch ptr=rob_tail, target=squash_rob_idx;
  - remaining = (rob_tail - squash_rob_idx - 1) mod N_ROB;
  - go to WALK if remaining>0, else go to DONE.
- dispatch_stall = squash_req | (state!=IDLE). It is combinational, so the stall covers the request cycle.
- WALK, each cycle:
  - k = min(N_WAY, remaining);
  - rd_idx[i] = ptr-1-i;
  - for lanes i<k: restore_valid[i] = free_valid[i] = 1; restore_dest = rd_dest, restore_tag = rd_told, free_tag = rd_tag;
  - lanes i>=k: strobes are 0, rd_idx is don't-care;
  - rob_tail_dec = k;
  - at the edge: ptr -= k, remaining -= k; go to DONE when the new remaining is 0.
- Lane ordering: the map table applies lanes in ascending order, so lane N_WAY-1 (the older entry) wins on an equal dest. This block does not merge lanes.
- Data outputs are combinational from rd_* in WALK and 0 in all other states.
- DONE: done=1 for one cycle and dispatch_stall=1. Next state is IDLE, unless squash_req is asserted, which is handled as in IDLE.
- squash_req while in WALK:
  - accepted only if Age(squash_rob_idx) < Age(target), i.e. the new branch is older;
  - on accept: target=new idx, and remaining = (ptr_next - idx - 1) mod N_ROB, where ptr_next is the value after this cycle's walk;
  - a younger or equal request is ignored, since it is already covered.
- The ROB must not accept dispatch or retire entries younger than head while busy. Retire of older entries is permitted.
- rob_tail and rob_head are sampled only on accept (and rob_head for the age compare).

Test Plan:
1. N_WAY=2, tail=10, idx=5, squash_req for 1 cycle:
   - cycle 1 (WALK): rd_idx {9,8}, both strobes set, rob_tail_dec=2;
   - cycle 2: rd_idx {7,6}, rob_tail_dec=2;
   - cycle 3: done=1;
   - dispatch_stall is 1 for 4 cycles, counting the request cycle.
2. tail=6, idx=5 -> DONE the next cycle; free_valid and restore_valid are never set; done pulses once.
3. Wrap: N_ROB=32, tail=1, idx=29 -> remaining=3. WALK produces rd_idx {0,31} with rob_tail_dec=2, then {30,x} with lane-1 strobes 0 and rob_tail_dec=1.
4. Nested squash: head=0, tail=20, idx=10 (remaining 9).
   - After the first WALK cycle a squash to idx=4 arrives -> remaining=(16-4-1)=11, and the walk continues to idx 5.
   - A later request with idx=15 is ignored.
5. reset=0 during the second WALK cycle -> all outputs 0 from the next cycle, busy=0, dispatch_stall=0 (absent squash_req).
6. Both lanes have rd_dest=3, with rd_told {40,33}: restore_dest {3,3}, restore_tag {40,33}; free_tag equals rd_tag per lane.

Source files
------------

// File: rtl/squash_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: walks the ROB from the tail toward the squashed branch,
// restoring map-table entries and returning tags to the free list, up to N_WAY entries per cycle.
module squash_recovery_ctrl #(
  parameter int unsigned N_WAY     = 2,
  parameter int unsigned N_ROB     = 32,
  parameter int unsigned CDB_BITS  = 6,
  parameter int unsigned ARCH_BITS = 5,
  localparam int unsigned IW       = $clog2(N_ROB),
  localparam int unsigned KW       = $clog2(N_WAY) + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 squash_req,
  input  logic [IW-1:0]                        squash_rob_idx,
  input  logic [IW-1:0]                        rob_head,
  input  logic [IW-1:0]                        rob_tail,
  output logic [N_WAY-1:0][IW-1:0]             rd_idx,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]       rd_tag,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]       rd_told,
  input  logic [N_WAY-1:0][ARCH_BITS-1:0]      rd_dest,
  output logic [N_WAY-1:0]                     restore_valid,
  output logic [N_WAY-1:0][ARCH_BITS-1:0]      restore_dest,
  output logic [N_WAY-1:0][CDB_BITS-1:0]       restore_tag,
  output logic [N_WAY-1:0]                     free_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]       free_tag,
  output logic [KW-1:0]                        rob_tail_dec,
  output logic                                 dispatch_stall,
  output logic                                 busy,
  output logic                                 done
);

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e        state_q;
  logic [IW-1:0] ptr_q, target_q, remaining_q;

  logic          walking;
  logic [KW-1:0] k;
  logic [IW-1:0] ptr_next, rem_next;
  logic [IW-1:0] start_rem, nested_rem;
  logic [IW-1:0] age_new, age_tgt;
  logic          nested_accept;

  assign walking = (state_q == StWalk);

  always_comb begin
    k = '0;
    if (walking) begin
      if (remaining_q >= IW'(N_WAY)) k = KW'(N_WAY);
      else                           k = KW'(remaining_q);
    end
  end

  assign ptr_next   = ptr_q - IW'(k);
  assign rem_next   = remaining_q - IW'(k);
  assign start_rem  = rob_tail - squash_rob_idx - IW'(1);
  assign nested_rem = ptr_next - squash_rob_idx - IW'(1);

  // A nested squash only matters if it is older than the branch we are already unwinding to.
  assign age_new       = squash_rob_idx - rob_head;
  assign age_tgt       = target_q - rob_head;
  assign nested_accept = walking && squash_req && (age_new < age_tgt);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      target_q    <= '0;
      remaining_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (squash_req) begin
            ptr_q       <= rob_tail;
            target_q    <= squash_rob_idx;
            remaining_q <= start_rem;
            state_q     <= (start_rem != '0) ? StWalk : StDone;
          end else begin
            state_q <= StIdle;
          end
        end
        StWalk: begin
          ptr_q <= ptr_next;
          if (nested_accept) begin
            target_q    <= squash_rob_idx;
            remaining_q <= nested_rem;
            state_q     <= (nested_rem != '0) ? StWalk : StDone;
          end else begin
            remaining_q <= rem_next;
            state_q     <= (rem_next != '0) ? StWalk : StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_idx        = '0;
    restore_valid = '0;
    free_valid    = '0;
    restore_dest  = '0;
    restore_tag   = '0;
    free_tag      = '0;
    if (walking) begin
      for (int unsigned i = 0; i < N_WAY; i++) begin
        rd_idx[i]        = ptr_q - IW'(i + 1);
        restore_valid[i] = (KW'(i) < k);
        free_valid[i]    = (KW'(i) < k);
        restore_dest[i]  = rd_dest[i];
        restore_tag[i]   = rd_told[i];
        free_tag[i]      = rd_tag[i];
      end
    end
  end

  assign rob_tail_dec   = k;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign dispatch_stall = squash_req | busy;

endmodule
